// File: rtl/ahb_mtx_in_stage_pkg.sv
// Shared AHB bus-matrix definitions: transfer/response encodings and the
// address-phase control bundle used by the input stages.
package ahb_mtx_in_stage_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    // Address-phase control fields; the address itself is kept alongside
    // because its width is a per-instance parameter.
    typedef struct packed {
        htrans_e    trans;
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic       lock;
    } aphase_ctrl_t;

    localparam aphase_ctrl_t APHASE_CTRL_RESET = '{
        trans: HTRANS_IDLE,
        write: 1'b0,
        size:  3'b000,
        burst: 3'b000,
        prot:  4'b0000,
        lock:  1'b0
    };

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never need holding.
    function automatic logic is_active_trans(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_mtx_in_stage.sv
// Bus-matrix input stage: passes the master's address phase straight to the
// decoder, or holds and replays it while the addressed output stage is busy.
module ahb_mtx_in_stage
    import ahb_mtx_in_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              active_dec,
    input  logic              readyout_dec,
    input  logic [1:0]        resp_dec,
    output logic              sel_dec,
    output logic [ADDR_W-1:0] addr_dec,
    output logic [1:0]        trans_dec,
    output logic              write_dec,
    output logic [2:0]        size_dec,
    output logic [2:0]        burst_dec,
    output logic [3:0]        prot_dec,
    output logic              lock_dec,
    output logic              ready_dec,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS,
    output logic              held
);

    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    aphase_ctrl_t      ctrl_q, ctrl_d;
    aphase_ctrl_t      ctrl_in;
    aphase_ctrl_t      ctrl_out;
    logic              accept;
    logic              hold_load;

    always_comb begin
        ctrl_in       = APHASE_CTRL_RESET;
        ctrl_in.trans = htrans_e'(HTRANSS);
        ctrl_in.write = HWRITES;
        ctrl_in.size  = HSIZES;
        ctrl_in.burst = HBURSTS;
        ctrl_in.prot  = HPROTS;
        ctrl_in.lock  = HMASTLOCKS;
    end

    assign accept    = HSELS & HREADYS & is_active_trans(HTRANSS);
    assign hold_load = HREADYS & ~pend_q;

    always_comb begin
        pend_d = pend_q;
        addr_d = addr_q;
        ctrl_d = ctrl_q;
        if (!pend_q) begin
            pend_d = accept & ~active_dec;
        end else if (active_dec) begin
            pend_d = 1'b0;
        end
        // Capture on every completed address phase; only meaningful once pend sets.
        if (hold_load) begin
            addr_d = HADDRS;
            ctrl_d = ctrl_in;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_q <= 1'b0;
            addr_q <= '0;
            ctrl_q <= APHASE_CTRL_RESET;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            ctrl_q <= ctrl_d;
        end
    end

    always_comb begin
        sel_dec    = HSELS;
        addr_dec   = HADDRS;
        ctrl_out   = ctrl_in;
        ready_dec  = HREADYS;
        HREADYOUTS = readyout_dec;
        HRESPS     = resp_dec;
        // Replay: the previous data phase is done, so the decoder sees HREADY high
        // while the master is stalled with an OKAY wait state.
        if (pend_q) begin
            sel_dec    = 1'b1;
            addr_dec   = addr_q;
            ctrl_out   = ctrl_q;
            ready_dec  = 1'b1;
            HREADYOUTS = 1'b0;
            HRESPS     = HRESP_OKAY;
        end
    end

    assign trans_dec = ctrl_out.trans;
    assign write_dec = ctrl_out.write;
    assign size_dec  = ctrl_out.size;
    assign burst_dec = ctrl_out.burst;
    assign prot_dec  = ctrl_out.prot;
    assign lock_dec  = ctrl_out.lock;
    assign held      = pend_q;

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// Directed bench for the bus-matrix input stage: pass-through, hold/replay,
// burst stall, error pass-through and asynchronous reset during a hold.
module tb_ahb_mtx_in_stage;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        active_dec;
    logic        readyout_dec;
    logic [1:0]  resp_dec;
    logic        sel_dec;
    logic [31:0] addr_dec;
    logic [1:0]  trans_dec;
    logic        write_dec;
    logic [2:0]  size_dec;
    logic [2:0]  burst_dec;
    logic [3:0]  prot_dec;
    logic        lock_dec;
    logic        ready_dec;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic        held;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_mtx_in_stage #(.ADDR_W(32)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .active_dec   (active_dec),
        .readyout_dec (readyout_dec),
        .resp_dec     (resp_dec),
        .sel_dec      (sel_dec),
        .addr_dec     (addr_dec),
        .trans_dec    (trans_dec),
        .write_dec    (write_dec),
        .size_dec     (size_dec),
        .burst_dec    (burst_dec),
        .prot_dec     (prot_dec),
        .lock_dec     (lock_dec),
        .ready_dec    (ready_dec),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS),
        .held         (held)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET       = 1'b1;
        HSELS        = 1'b0;
        HADDRS       = 32'h0;
        HTRANSS      = 2'b00;
        HWRITES      = 1'b0;
        HSIZES       = 3'b000;
        HBURSTS      = 3'b000;
        HPROTS       = 4'b0000;
        HMASTLOCKS   = 1'b0;
        HREADYS      = 1'b1;
        active_dec   = 1'b1;
        readyout_dec = 1'b1;
        resp_dec     = 2'b00;

        // Reset: pass-through equations with pend clear
        #1;
        check("rst_held",   32'(held), 32'd0);
        check("rst_sel",    32'(sel_dec), 32'd0);
        check("rst_ready",  32'(ready_dec), 32'd1);
        check("rst_hrdy",   32'(HREADYOUTS), 32'd1);
        check("rst_hresp",  32'(HRESPS), 32'd0);
        cyc();
        cyc();
        HRESET = 1'b0;

        // Granted pass-through, zero latency
        cyc();
        HSELS = 1'b1; HADDRS = 32'h4003_0000; HTRANSS = 2'b10; HWRITES = 1'b1;
        HSIZES = 3'b010; HBURSTS = 3'b000; HPROTS = 4'b0011; HMASTLOCKS = 1'b0;
        active_dec = 1'b1; readyout_dec = 1'b1;
        #1;
        check("pt_addr",  addr_dec, 32'h4003_0000);
        check("pt_trans", 32'(trans_dec), 32'd2);
        check("pt_write", 32'(write_dec), 32'd1);
        check("pt_prot",  32'(prot_dec), 32'd3);
        check("pt_held",  32'(held), 32'd0);
        check("pt_hrdy",  32'(HREADYOUTS), 32'd1);

        // Single stall: held for 4 cycles (active low 3 held cycles, then high)
        cyc();
        check("pt_held_after", 32'(held), 32'd0);
        HADDRS = 32'h6004_0000; HTRANSS = 2'b10; HWRITES = 1'b0; HSIZES = 3'b001;
        HBURSTS = 3'b001; HPROTS = 4'b1010; HMASTLOCKS = 1'b1; active_dec = 1'b0;
        #1;
        check("st_n_held", 32'(held), 32'd0);
        check("st_n_addr", addr_dec, 32'h6004_0000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            // master inputs deliberately scrambled to prove the replay comes from the hold
            HSELS = 1'b0; HADDRS = 32'hDEAD_0000; HTRANSS = 2'b00; HWRITES = 1'b1;
            HSIZES = 3'b000; HBURSTS = 3'b000; HPROTS = 4'b0000; HMASTLOCKS = 1'b0;
            HREADYS = 1'b0; readyout_dec = 1'b1;
            active_dec = (i == 3);
            #1;
            check("st_held",  32'(held), 32'd1);
            check("st_hrdy",  32'(HREADYOUTS), 32'd0);
            check("st_hresp", 32'(HRESPS), 32'd0);
            check("st_addr",  addr_dec, 32'h6004_0000);
            check("st_sel",   32'(sel_dec), 32'd1);
            check("st_ready", 32'(ready_dec), 32'd1);
            check("st_trans", 32'(trans_dec), 32'd2);
            check("st_write", 32'(write_dec), 32'd0);
            check("st_size",  32'(size_dec), 32'd1);
            check("st_burst", 32'(burst_dec), 32'd1);
            check("st_prot",  32'(prot_dec), 32'ha);
            check("st_lock",  32'(lock_dec), 32'd1);
        end
        cyc();
        HSELS = 1'b0; HTRANSS = 2'b00; HREADYS = 1'b1; active_dec = 1'b1; readyout_dec = 1'b1;
        #1;
        check("st_rel_held", 32'(held), 32'd0);
        check("st_rel_hrdy", 32'(HREADYOUTS), 32'd1);
        check("st_rel_sel",  32'(sel_dec), 32'd0);

        // IDLE and BUSY never held
        cyc();
        HSELS = 1'b1; HTRANSS = 2'b00; active_dec = 1'b0; readyout_dec = 1'b0;
        #1;
        check("idle_hrdy", 32'(HREADYOUTS), 32'd0);
        cyc();
        check("idle_held", 32'(held), 32'd0);
        HTRANSS = 2'b01; readyout_dec = 1'b1;
        #1;
        check("busy_hrdy", 32'(HREADYOUTS), 32'd1);
        cyc();
        check("busy_held", 32'(held), 32'd0);

        // SEQ burst of 4; beat 3 (0x0C) sees one cycle of active_dec low
        for (int b = 0; b < 4; b++) begin
            if (b != 0) cyc();
            HSELS = 1'b1; HTRANSS = (b == 0) ? 2'b10 : 2'b11; HBURSTS = 3'b011;
            HADDRS = 32'h2000_0000 + 32'(4 * b); HREADYS = 1'b1; readyout_dec = 1'b1;
            active_dec = (b != 3);
            #1;
            check("bu_addr", addr_dec, 32'h2000_0000 + 32'(4 * b));
            check("bu_held", 32'(held), 32'd0);
        end
        cyc();
        HREADYS = 1'b0; active_dec = 1'b1;
        #1;
        check("bu_st_held", 32'(held), 32'd1);
        check("bu_st_addr", addr_dec, 32'h2000_000C);
        check("bu_st_hrdy", 32'(HREADYOUTS), 32'd0);
        cyc();
        HREADYS = 1'b1; HTRANSS = 2'b00;
        #1;
        check("bu_end_held", 32'(held), 32'd0);

        // ERROR response pass-through while not pending
        resp_dec = 2'b01; readyout_dec = 1'b0;
        #1;
        check("err1_hresp", 32'(HRESPS), 32'd1);
        check("err1_hrdy",  32'(HREADYOUTS), 32'd0);
        cyc();
        readyout_dec = 1'b1;
        #1;
        check("err2_hresp", 32'(HRESPS), 32'd1);
        check("err2_hrdy",  32'(HREADYOUTS), 32'd1);
        cyc();
        resp_dec = 2'b00;

        // Asynchronous reset in the middle of a hold
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h1000_0400; HREADYS = 1'b1;
        active_dec = 1'b0; readyout_dec = 1'b1;
        cyc();
        HREADYS = 1'b0;
        #1;
        check("ar_held_pre", 32'(held), 32'd1);
        check("ar_hrdy_pre", 32'(HREADYOUTS), 32'd0);
        #2;
        HRESET = 1'b1;
        #1;
        check("ar_held",  32'(held), 32'd0);
        check("ar_hrdy",  32'(HREADYOUTS), 32'd1);
        check("ar_ready", 32'(ready_dec), 32'd0);
        #2;
        HRESET = 1'b0;
        HTRANSS = 2'b00; HREADYS = 1'b1; readyout_dec = 1'b0;
        cyc();
        check("ar_post_held", 32'(held), 32'd0);
        check("ar_post_hrdy", 32'(HREADYOUTS), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
